// File: rtl/temp_bcd_encoder_if.sv
// temp_bcd_encoder_if: request/result bundle between the temperature path and the BCD display encoder
interface temp_bcd_encoder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic [3:0]       d3;
  logic [3:0]       d2;
  logic [3:0]       d1;
  logic [3:0]       d0;
  modport master (output start, value, input busy, done, d3, d2, d1, d0);
  modport slave  (input start, value, output busy, done, d3, d2, d1, d0);
endinterface

// File: rtl/temp_bcd_encoder.sv
// temp_bcd_encoder: signed binary to sign/3-digit display codes via double-dabble; TEMP_LZB_EN enables leading-zero blanking
module temp_bcd_encoder #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  temp_bcd_encoder_if.slave bus
);
  localparam logic [3:0] BLANK = 4'd10;
  localparam logic [3:0] MINUS = 4'd11;
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  state_t           state;
  logic             neg;
  logic [WIDTH-1:0] mag;
  logic [11:0]      bcd;
  logic [3:0]       cnt;
  logic [11:0]      adj;
  logic [WIDTH-1:0] absval;
  logic [3:0]       f3, f2, f1, f0;
  // two's-complement magnitude kept at WIDTH bits so the most negative value maps to 2^(WIDTH-1)
  always_comb absval = bus.value[WIDTH-1] ? -bus.value : bus.value;
  // add-3 correction on every BCD nibble that would overflow when doubled
  always_comb begin
    adj[11:8] = bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8];
    adj[7:4]  = bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4];
    adj[3:0]  = bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0];
  end
`ifdef TEMP_LZB_EN
  logic z2, z1;
  // blank leading zeros and slide the minus sign next to the first significant digit
  always_comb begin
    z2 = bcd[11:8] == 4'd0;
    z1 = z2 && bcd[7:4] == 4'd0;
    f3 = (!z2 && neg) ? MINUS : BLANK;
    f2 = !z2 ? bcd[11:8] : (neg && !z1) ? MINUS : BLANK;
    f1 = !z1 ? bcd[7:4] : neg ? MINUS : BLANK;
    f0 = bcd[3:0];
  end
`else
  // fixed layout: sign column then three digits with leading zeros
  always_comb begin
    f3 = neg ? MINUS : BLANK;
    f2 = bcd[11:8];
    f1 = bcd[7:4];
    f0 = bcd[3:0];
  end
`endif
  // conversion FSM with registered handshake and display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      neg      <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.d3   <= BLANK;
      bus.d2   <= BLANK;
      bus.d1   <= BLANK;
      bus.d0   <= BLANK;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          neg      <= bus.value[WIDTH-1];
          mag      <= absval;
          bcd      <= '0;
          cnt      <= 4'(WIDTH);
          bus.busy <= 1'b1;
          state    <= SHIFT;
        end
        SHIFT: begin
          bcd   <= {adj[10:0], mag[WIDTH-1]};
          mag   <= {mag[WIDTH-2:0], 1'b0};
          cnt   <= cnt - 4'd1;
          state <= cnt == 4'd1 ? FORMAT : SHIFT;
        end
        default: begin
          bus.d3   <= f3;
          bus.d2   <= f2;
          bus.d1   <= f1;
          bus.d0   <= f0;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_temp_bcd_encoder.sv
// tb_temp_bcd_encoder: scoreboard bench for temp_bcd_encoder, WIDTH=8, both TEMP_LZB_EN builds
module tb_temp_bcd_encoder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int dones = 0;
  logic [15:0] sb[$];
  temp_bcd_encoder_if #(.WIDTH(W)) bus ();
  temp_bcd_encoder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input logic [7:0] v);
    int m;
    int d[4];
    int lead;
    logic n;
    n = v[7];
    m = n ? 256 - int'(v) : int'(v);
    d[0] = 10;
    d[1] = m / 100;
    d[2] = (m / 10) % 10;
    d[3] = m % 10;
`ifdef TEMP_LZB_EN
    lead = d[1] != 0 ? 1 : d[2] != 0 ? 2 : 3;
    for (int i = 1; i < lead; i++) d[i] = 10;
    if (n) d[lead-1] = 11;
`else
    lead = 0;
    if (n) d[0] = 11;
`endif
    return {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
  endfunction
  // scoreboard: every done pulse pops and compares one expected result
  always @(negedge clk) if (bus.done) begin
    dones++;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_done got %h with empty scoreboard", {bus.d3, bus.d2, bus.d1, bus.d0});
    end else begin
      logic [15:0] e;
      e = sb.pop_front();
      if ({bus.d3, bus.d2, bus.d1, bus.d0} !== e) begin
        errors++;
        $display("FAIL result got %h expected %h", {bus.d3, bus.d2, bus.d1, bus.d0}, e);
      end
    end
  end
  task automatic wait_done();
    int i;
    for (i = 0; i < 20 && bus.done !== 1'b1; i++) @(posedge clk) #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got done=%b expected 1 within 20 cycles", bus.done);
    end
  endtask
  task automatic run(input logic [7:0] v, input logic [15:0] e);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk) #1;
    bus.start = 1'b0;
    wait_done();
  endtask
  task automatic test_reset();
    bus.start = 1'b0;
    bus.value = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.d3, bus.d2, bus.d1, bus.d0} !== {2'b00, 16'hAAAA}) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b d=%h expected 0 0 aaaa", bus.busy, bus.done, {bus.d3, bus.d2, bus.d1, bus.d0});
    end
  endtask
  task automatic test_basic();
    int nb;
    int nd;
    nb = 0;
    nd = 0;
`ifdef TEMP_LZB_EN
    sb.push_back(16'hAA42);
`else
    sb.push_back(16'hA042);
`endif
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 8'd42;
    @(posedge clk) #1;
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy === 1'b1) nb++;
      if (bus.done === 1'b1) begin
        nd++;
        checks++;
        if (i != 9) begin
          errors++;
          $display("FAIL done_latency got edge %0d expected 9", i);
        end
      end
      @(posedge clk) #1;
    end
    checks += 2;
    if (nb != 9) begin
      errors++;
      $display("FAIL busy_cycles got %0d expected 9", nb);
    end
    if (nd != 1) begin
      errors++;
      $display("FAIL done_pulses got %0d expected 1", nd);
    end
  endtask
  task automatic test_values();
`ifdef TEMP_LZB_EN
    run(8'hFB, 16'hAAB5);
    run(8'h80, 16'hB128);
    run(8'h7F, 16'hA127);
    run(8'h00, 16'hAAA0);
`else
    run(8'hFB, 16'hB005);
    run(8'h80, 16'hB128);
    run(8'h7F, 16'hA127);
    run(8'h00, 16'hA000);
`endif
  endtask
  task automatic test_sweep();
    for (int v = 0; v < 256; v++) run(8'(v), model(8'(v)));
    @(posedge clk) #1;
  endtask
  task automatic test_back_to_back();
    int nd;
    nd = 0;
    sb.push_back(model(8'd42));
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 8'd42;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1;
      if (i == 0 || i == 3) bus.start = 1'b0;
      if (i == 2) begin
        bus.start = 1'b1;
        bus.value = 8'd99;
      end
      if (bus.done === 1'b1) nd++;
    end
    checks++;
    if (nd != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy_start got dones=%0d busy=%b expected 1 0", nd, bus.busy);
    end
`ifdef TEMP_LZB_EN
    sb.push_back(16'hAA99);
`else
    sb.push_back(16'hA099);
`endif
    bus.start = 1'b1;
    bus.value = 8'd99;
    @(posedge clk) #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_on_done got busy=%b expected 1", bus.busy);
    end
    wait_done();
    @(posedge clk) #1;
  endtask
  task automatic test_reset_mid();
    int d;
    run(8'd42, model(8'd42));
    @(posedge clk) #1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.value = 8'hB3;
    @(posedge clk) #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk) #1;
    checks++;
    if ({bus.busy, bus.done, bus.d3, bus.d2, bus.d1, bus.d0} !== {2'b00, 16'hAAAA}) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b d=%h expected 0 0 aaaa", bus.busy, bus.done, {bus.d3, bus.d2, bus.d1, bus.d0});
    end
    rst_n = 1'b1;
    d = dones;
    repeat (14) @(posedge clk);
    #1;
    checks++;
    if (dones != d) begin
      errors++;
      $display("FAIL no_done_after_reset got %0d pulses expected 0", dones - d);
    end
`ifdef TEMP_LZB_EN
    run(8'hB3, 16'hAB77);
`else
    run(8'hB3, 16'hB077);
`endif
    @(posedge clk) #1;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_values();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
